// File: rtl/pcie2ram_led_sequencer.sv
// Walks a host-written table of 64-bit entries in the shared RAM (port B, read only)
// and shows each entry's LED pattern for its programmed hold time.
module pcie2ram_led_sequencer #(
    parameter int ADDR_W = 12,
    parameter int LED_W  = 8,
    parameter int DUR_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    input  logic [63:0]       ram_readdata,
    output logic [LED_W-1:0]  led,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] cur_addr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        HOLD   = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [DUR_W-1:0]  cnt;
    logic              halt_seen;
    logic [DUR_W-1:0]  entry_dur;
    logic              entry_halt;
    logic              entry_end;
    logic              unused_rsv;

    assign entry_dur  = ram_readdata[8 +: DUR_W];
    assign entry_halt = ram_readdata[62];
    assign entry_end  = ram_readdata[63];
    assign unused_rsv = ^ram_readdata[61:8+DUR_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping enable anywhere in the fetch/display loop aborts straight to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = FETCH;
            FETCH:   state_next = enable ? WAIT : IDLE;
            WAIT:    state_next = enable ? HOLD : IDLE;
            HOLD: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = halt_seen ? HALTED : FETCH;
                end
            end
            HALTED:  if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            led       <= '0;
            cnt       <= '0;
            cur_addr  <= '0;
            halt_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) ptr <= start_addr;
                end
                // An aborted read is simply not captured, so led keeps its old value.
                WAIT: begin
                    if (enable) begin
                        led       <= ram_readdata[LED_W-1:0];
                        cnt       <= (entry_dur == '0) ? '0 : entry_dur - 1'b1;
                        cur_addr  <= ptr;
                        halt_seen <= entry_halt;
                        ptr       <= entry_end ? start_addr : ptr + 1'b1;
                    end
                end
                HOLD: begin
                    if (enable && cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_chipselect = (state == FETCH);
        ram_address    = ptr;
        busy           = (state != IDLE) && (state != HALTED);
        halted         = (state == HALTED);
    end

endmodule

// File: tb/tb_pcie2ram_led_sequencer.sv
// Bench for the LED sequencer: a RAM model, directed table runs, an entry-decode table
// and randomized tables, all checked against an entry-level schedule of expected cycles.
module tb_pcie2ram_led_sequencer;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [11:0] start_addr;
    logic [11:0] ram_address;
    logic        ram_chipselect;
    logic [63:0] ram_readdata;
    logic [7:0]  led;
    logic        busy;
    logic        halted;
    logic [11:0] cur_addr;

    pcie2ram_led_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .start_addr     (start_addr),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_readdata   (ram_readdata),
        .led            (led),
        .busy           (busy),
        .halted         (halted),
        .cur_addr       (cur_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port-B RAM: address registered on a chipselect edge, data read combinationally.
    logic [63:0] mem [0:4095];
    logic [11:0] rd_addr;
    initial rd_addr = '0;
    always @(posedge clk) if (ram_chipselect) rd_addr <= ram_address;
    assign ram_readdata = mem[rd_addr];

    typedef struct {
        logic        cs;
        logic [11:0] addr;
        logic [7:0]  led;
        logic        busy;
        logic        halted;
        logic [11:0] cur;
    } exp_t;

    typedef struct {
        logic [63:0] entry;
        logic [7:0]  exp_led;
        int          exp_gap;
        logic        exp_halt;
        logic [11:0] exp_next;
    } vec_t;

    exp_t        exp_q [$];
    vec_t        vecs [8];
    int          vectors;
    int          miscompares;
    logic [7:0]  last_led;
    logic [11:0] last_cur;

    function automatic logic [63:0] make_entry(input logic [7:0] pat, input logic [31:0] d,
                                               input logic hlt, input logic fin,
                                               input logic [21:0] rsv);
        return {fin, hlt, rsv, d, pat};
    endfunction

    // Expand the table walk into one expected record per clock cycle.
    task automatic build_expect(input logic [11:0] start, input int n);
        logic [11:0] p;
        logic [7:0]  l;
        logic [11:0] c;
        logic [63:0] e;
        longint      d;
        exp_q.delete();
        p = start;
        l = last_led;
        c = last_cur;
        while (exp_q.size() < n) begin
            e = mem[p];
            exp_q.push_back('{1'b1, p, l, 1'b1, 1'b0, c});
            exp_q.push_back('{1'b0, p, l, 1'b1, 1'b0, c});
            l = e[7:0];
            c = p;
            d = (e[39:8] == 32'd0) ? 64'd1 : longint'(e[39:8]);
            for (longint j = 0; j < d && exp_q.size() < n; j++)
                exp_q.push_back('{1'b0, p, l, 1'b1, 1'b0, c});
            if (e[62]) begin
                while (exp_q.size() < n) exp_q.push_back('{1'b0, p, l, 1'b0, 1'b1, c});
            end else begin
                p = e[63] ? start : p + 12'd1;
            end
        end
    endtask

    task automatic check_output(input string tag, input exp_t e);
        vectors++;
        if (ram_chipselect !== e.cs || (e.cs && ram_address !== e.addr) || led !== e.led ||
            busy !== e.busy || halted !== e.halted || cur_addr !== e.cur) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got cs=%b addr=%h led=%h busy=%b halted=%b cur=%h, expected cs=%b addr=%h led=%h busy=%b halted=%b cur=%h",
                     tag, $time, ram_chipselect, ram_address, led, busy, halted, cur_addr,
                     e.cs, e.addr, e.led, e.busy, e.halted, e.cur);
        end
    endtask

    task automatic check_value(input string tag, input longint got, input longint want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic apply_stimulus(input logic [11:0] start, input int n, input string tag);
        build_expect(start, n);
        start_addr = start;
        enable     = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_output(tag, exp_q[i]);
        end
        last_led = exp_q[n-1].led;
        last_cur = exp_q[n-1].cur;
    endtask

    task automatic abort_and_check(input string tag, input int k);
        enable = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check_output(tag, '{1'b0, 12'd0, last_led, 1'b0, 1'b0, last_cur});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        last_led = 8'd0;
        last_cur = 12'd0;
    endtask

    initial begin
        int          event_cyc;
        logic        ev_cs;
        logic [11:0] ev_addr;
        logic [7:0]  led_seen;
        logic [11:0] base;
        logic [11:0] a;

        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 64'd0;

        // entry, displayed pattern, cycles until next fetch or halt, halts?, next fetch address
        vecs[0] = '{make_entry(8'hA5, 32'd3,   1'b0, 1'b0, 22'd0),       8'hA5, 5,   1'b0, 12'h101};
        vecs[1] = '{make_entry(8'h5A, 32'd0,   1'b0, 1'b0, 22'd0),       8'h5A, 3,   1'b0, 12'h101};
        vecs[2] = '{make_entry(8'h3C, 32'd1,   1'b0, 1'b0, 22'd0),       8'h3C, 3,   1'b0, 12'h101};
        vecs[3] = '{make_entry(8'h96, 32'd10,  1'b0, 1'b1, 22'd0),       8'h96, 12,  1'b0, 12'h100};
        vecs[4] = '{make_entry(8'h81, 32'd2,   1'b1, 1'b0, 22'd0),       8'h81, 4,   1'b1, 12'h000};
        vecs[5] = '{make_entry(8'h42, 32'd0,   1'b1, 1'b1, 22'd0),       8'h42, 3,   1'b1, 12'h000};
        vecs[6] = '{make_entry(8'hFF, 32'd4,   1'b0, 1'b0, 22'h3FFFFF),  8'hFF, 6,   1'b0, 12'h101};
        vecs[7] = '{make_entry(8'h18, 32'd256, 1'b0, 1'b0, 22'h155555),  8'h18, 258, 1'b0, 12'h101};

        // Reset held with enable high, then release into the 0x010 table.
        mem[12'h010] = make_entry(8'hA5, 32'd3, 1'b0, 1'b0, 22'd0);
        mem[12'h011] = make_entry(8'h5A, 32'd0, 1'b0, 1'b1, 22'd0);
        reset_n    = 1'b0;
        enable     = 1'b1;
        start_addr = 12'h010;
        last_led   = 8'd0;
        last_cur   = 12'd0;
        repeat (3) @(negedge clk);
        check_output("reset_hold", '{1'b0, 12'd0, 8'd0, 1'b0, 1'b0, 12'd0});
        check_value("reset_addr", ram_address, 0);
        reset_n = 1'b1;
        apply_stimulus(12'h010, 40, "table_010");
        abort_and_check("abort_010", 3);

        // Address wrap 0xFFF -> 0x000 into a HALT entry, then sit halted with enable high.
        mem[12'hFFF] = make_entry(8'h01, 32'd2, 1'b0, 1'b0, 22'd0);
        mem[12'h000] = make_entry(8'h02, 32'd1, 1'b1, 1'b0, 22'd0);
        apply_stimulus(12'hFFF, 30, "wrap_halt");
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_output("halted_hold", exp_q[exp_q.size()-1]);
        end
        abort_and_check("halted_exit", 2);
        apply_stimulus(12'hFFF, 10, "halted_restart");
        abort_and_check("restart_abort", 2);

        // Abort during a long hold, then restart from a different table.
        mem[12'h030] = make_entry(8'hC3, 32'd100, 1'b0, 1'b0, 22'd0);
        apply_stimulus(12'h030, 20, "long_hold");
        abort_and_check("long_abort", 5);
        mem[12'h020] = make_entry(8'h11, 32'd2, 1'b0, 1'b0, 22'd0);
        mem[12'h021] = make_entry(8'h22, 32'd1, 1'b0, 1'b1, 22'd0);
        apply_stimulus(12'h020, 20, "restart_020");
        abort_and_check("abort_020", 2);

        // Asynchronous reset in the middle of WAIT.
        mem[12'h040] = make_entry(8'h77, 32'd3, 1'b0, 1'b0, 22'd0);
        apply_stimulus(12'h040, 2, "to_wait");
        #2 reset_n = 1'b0;
        #1 check_output("async_reset", '{1'b0, 12'd0, 8'd0, 1'b0, 1'b0, 12'd0});
        @(negedge clk);
        enable  = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check_output("post_reset_idle", '{1'b0, 12'd0, 8'd0, 1'b0, 1'b0, 12'd0});
        last_led = 8'd0;
        last_cur = 12'd0;

        // Entry-decode table: pattern, display length, HALT/END handling.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            mem[12'h100] = vecs[v].entry;
            mem[12'h101] = make_entry(8'hEE, 32'd1, 1'b1, 1'b0, 22'd0);
            start_addr = 12'h100;
            enable     = 1'b1;
            event_cyc  = -1;
            ev_cs      = 1'b0;
            ev_addr    = 12'd0;
            led_seen   = 8'd0;
            for (int c = 0; c < 300 && event_cyc < 0; c++) begin
                @(negedge clk);
                if (c == 2) led_seen = led;
                if (c >= 1 && (ram_chipselect || halted)) begin
                    event_cyc = c;
                    ev_cs     = ram_chipselect;
                    ev_addr   = ram_address;
                end
            end
            check_value($sformatf("vec%0d_led", v), led_seen, vecs[v].exp_led);
            check_value($sformatf("vec%0d_gap", v), event_cyc, vecs[v].exp_gap);
            check_value($sformatf("vec%0d_halt", v), halted, vecs[v].exp_halt);
            if (!vecs[v].exp_halt)
                check_value($sformatf("vec%0d_next", v), ev_addr, vecs[v].exp_next);
            else
                check_value($sformatf("vec%0d_noread", v), ev_cs, 0);
            enable = 1'b0;
        end
        do_reset();

        // Randomized tables, random run lengths, aborts and restarts.
        for (int it = 0; it < 30; it++) begin
            base = 12'($urandom_range(0, 4095));
            if (it % 4 == 0) base = 12'hFFD;
            for (int k = 0; k < 6; k++) begin
                a = base + 12'(k);
                mem[a] = make_entry(8'($urandom), $urandom_range(0, 6),
                                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                                    22'($urandom));
            end
            apply_stimulus(base, int'($urandom_range(8, 60)), "random_run");
            abort_and_check("random_abort", 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
